// File: rtl/core_tb_pkg.sv
// Shared definitions for the core run monitor: FSM encoding, default bus
// width and the FIPS-197 AES-128 reference vector the core is expected to hit.
package core_tb_pkg;

   localparam int DATA_W_DEF = 128;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HOLD = 3'd1,
      ST_RUN  = 3'd2,
      ST_PASS = 3'd3,
      ST_FAIL = 3'd4
   } run_state_e;

   localparam logic [127:0] FIPS_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PLAIN  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CIPHER = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   // A run is in progress while the core is held in reset or running.
   function automatic logic state_busy(input run_state_e s);
      return (s == ST_HOLD) || (s == ST_RUN);
   endfunction

endpackage

// File: rtl/core_run_monitor_if.sv
// Control/observation bundle between the run monitor and whoever drives it
// (top-level glue or a bench). The monitor side uses the slave modport.
interface core_run_monitor_if
   import core_tb_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int NUM_VEC = 4,
   parameter int CNT_W   = 32
);
   localparam int AW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
   localparam int MW = $clog2(NUM_VEC + 1);

   logic              start;
   logic              exp_we;
   logic [AW-1:0]     exp_addr;
   logic [DATA_W-1:0] exp_data;
   logic [DATA_W-1:0] state_i;
   logic              core_rst_n;
   logic              busy;
   logic              done;
   logic              pass;
   logic              fail;
   logic [MW-1:0]     match_cnt;
   logic [CNT_W-1:0]  cycle_cnt;

   modport master (
      output start, exp_we, exp_addr, exp_data, state_i,
      input  core_rst_n, busy, done, pass, fail, match_cnt, cycle_cnt
   );

   modport slave (
      input  start, exp_we, exp_addr, exp_data, state_i,
      output core_rst_n, busy, done, pass, fail, match_cnt, cycle_cnt
   );

endinterface

// File: rtl/core_rst_gen.sv
// Core reset generator: holds core_rst_n low for RST_HOLD cycles of HOLD,
// then releases it on the edge that moves the monitor into RUN. The reset
// stays released afterwards until the next accepted start.
module core_rst_gen #(
   parameter int RST_HOLD = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic in_hold,
   output logic hold_last,
   output logic core_rst_n
);
   localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          core_rst_n_q, core_rst_n_d;

   assign hold_last  = in_hold && (hold_cnt_q == HOLD_LAST);
   assign core_rst_n = core_rst_n_q;

   // Restart the hold window on a new run, count through HOLD, release at the end.
   always_comb begin
      hold_cnt_d   = hold_cnt_q;
      core_rst_n_d = core_rst_n_q;
      if (load) begin
         hold_cnt_d   = '0;
         core_rst_n_d = 1'b0;
      end else if (in_hold) begin
         if (hold_last) begin
            core_rst_n_d = 1'b1;
         end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
         end
      end
   end

   // Counter and reset output flops; the core sits in reset after a system reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q   <= '0;
         core_rst_n_q <= 1'b0;
      end else begin
         hold_cnt_q   <= hold_cnt_d;
         core_rst_n_q <= core_rst_n_d;
      end
   end

endmodule

// File: rtl/core_run_monitor.sv
// Run controller and result checker for the MIPS/AES core. Resets the core,
// then watches its state bus for an ordered list of expected values and
// reports pass, timeout failure and the number of RUN cycles used.
module core_run_monitor
   import core_tb_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_VEC  = 4,
   parameter int RST_HOLD = 4,
   parameter int TIMEOUT  = 50000,
   parameter int CNT_W    = 32
) (
   input logic               clk,
   input logic               rst_n,
   core_run_monitor_if.slave bus
);
   localparam int MW = $clog2(NUM_VEC + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   run_state_e        state_q, state_d;
   logic [MW-1:0]     match_cnt_q, match_cnt_d;
   logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
   logic [DATA_W-1:0] prev_q, prev_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic [DATA_W-1:0] exp_q [NUM_VEC];
   logic [DATA_W-1:0] exp_d [NUM_VEC];
   logic [DATA_W-1:0] exp_cur;

   logic start_ok;
   logic exp_wr;
   logic in_run;
   logic is_match;
   logic final_match;
   logic timeout_hit;
   logic hold_last;
   logic core_rst_n_w;

   assign start_ok    = bus.start && !state_busy(state_q);
   assign exp_wr      = bus.exp_we && !state_busy(state_q) && (int'(bus.exp_addr) < NUM_VEC);
   assign in_run      = (state_q == ST_RUN);
   assign is_match    = in_run && (bus.state_i == exp_cur) && (bus.state_i != prev_q);
   assign final_match = is_match && (int'(match_cnt_q) == NUM_VEC - 1);
   assign timeout_hit = in_run && (cycle_cnt_q == TIMEOUT_LAST);

   core_rst_gen #(
      .RST_HOLD (RST_HOLD)
   ) u_rst_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (start_ok),
      .in_hold    (state_q == ST_HOLD),
      .hold_last  (hold_last),
      .core_rst_n (core_rst_n_w)
   );

   assign bus.core_rst_n = core_rst_n_w;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = pass_q;
   assign bus.fail       = fail_q;
   assign bus.match_cnt  = match_cnt_q;
   assign bus.cycle_cnt  = cycle_cnt_q;

   // Expected-value table update; a write landing with start is seen by that run.
   always_comb begin
      exp_d = exp_q;
      for (int i = 0; i < NUM_VEC; i++) begin
         if (exp_wr && (int'(bus.exp_addr) == i)) begin
            exp_d[i] = bus.exp_data;
         end
      end
   end

   // Pick the table entry the run is currently waiting for.
   always_comb begin
      exp_cur = '0;
      for (int i = 0; i < NUM_VEC; i++) begin
         if (int'(match_cnt_q) == i) begin
            exp_cur = exp_q[i];
         end
      end
   end

   // Run sequencing: start -> HOLD -> RUN, then PASS on the last match or FAIL on timeout.
   always_comb begin
      state_d     = state_q;
      match_cnt_d = match_cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      prev_d      = prev_q;
      case (state_q)
         ST_IDLE, ST_PASS, ST_FAIL: begin
            if (start_ok) begin
               state_d     = ST_HOLD;
               match_cnt_d = '0;
               cycle_cnt_d = '0;
               prev_d      = '0;
            end
         end
         ST_HOLD: begin
            if (hold_last) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            cycle_cnt_d = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
            prev_d      = bus.state_i;
            if (is_match) begin
               match_cnt_d = match_cnt_q + MW'(1);
            end
            if (final_match) begin
               state_d = ST_PASS;
            end else if (timeout_hit) begin
               state_d = ST_FAIL;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = state_busy(state_d);
      done_d = (state_d == ST_PASS) || (state_d == ST_FAIL);
      pass_d = (state_d == ST_PASS);
      fail_d = (state_d == ST_FAIL);
   end

   // State, counters, flags and table; system reset returns everything to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         match_cnt_q <= '0;
         cycle_cnt_q <= '0;
         prev_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         for (int i = 0; i < NUM_VEC; i++) begin
            exp_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         match_cnt_q <= match_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
         prev_q      <= prev_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         for (int i = 0; i < NUM_VEC; i++) begin
            exp_q[i] <= exp_d[i];
         end
      end
   end

endmodule

// File: tb/tb_core_run_monitor.sv
// Self-checking bench for core_run_monitor with two expected entries and a
// short timeout. Each driven cycle pushes its expected outputs to a queue
// that is popped and compared once the DUT has clocked that cycle.
module tb_core_run_monitor;
   import core_tb_pkg::*;

   localparam int NV = 2;
   localparam int TO = 200;
   localparam int RH = 4;

   typedef struct packed {
      logic        rstn;
      logic        busy;
      logic        done;
      logic        pass;
      logic        fail;
      logic [1:0]  mcnt;
      logic [31:0] ccnt;
   } out_t;

   typedef struct packed {
      logic         start;
      logic         we;
      logic         addr;
      logic [127:0] data;
      logic [127:0] st;
      out_t         exp;
   } vec_t;

   localparam logic [127:0] A = FIPS_KEY;
   localparam logic [127:0] B = FIPS_PLAIN;
   localparam logic [127:0] C = FIPS_CIPHER;
   localparam logic [127:0] P = FIPS_PLAIN;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   int   checks = 0;
   int   errors = 0;
   out_t sb[$];
   vec_t tv[$];

   core_run_monitor_if #(.DATA_W(128), .NUM_VEC(NV), .CNT_W(32)) bus();

   core_run_monitor #(
      .DATA_W   (128),
      .NUM_VEC  (NV),
      .RST_HOLD (RH),
      .TIMEOUT  (TO),
      .CNT_W    (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic out_t o(input logic rstn, input logic busy, input logic done,
                              input logic pass, input logic fail, input int m, input int c);
      out_t r;
      r.rstn = rstn; r.busy = busy; r.done = done; r.pass = pass; r.fail = fail;
      r.mcnt = 2'(m);
      r.ccnt = 32'(c);
      return r;
   endfunction

   function automatic out_t idleO();         return o(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0); endfunction
   function automatic out_t holdO();         return o(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0); endfunction
   function automatic out_t runO(int m, int c); return o(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, m, c); endfunction
   function automatic out_t passO(int c);    return o(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2, c); endfunction
   function automatic out_t failO(int m, int c); return o(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, m, c); endfunction

   function automatic vec_t mk(input logic start, input logic we, input logic addr,
                               input logic [127:0] data, input logic [127:0] st, input out_t e);
      vec_t v;
      v.start = start; v.we = we; v.addr = addr; v.data = data; v.st = st; v.exp = e;
      return v;
   endfunction

   // Drive one cycle of inputs, queue its expected result, and clock it.
   task automatic applyStimulus(input vec_t v);
      bus.start    = v.start;
      bus.exp_we   = v.we;
      bus.exp_addr = v.addr;
      bus.exp_data = v.data;
      bus.state_i  = v.st;
      sb.push_back(v.exp);
      @(posedge clk);
      #1;
   endtask

   // Pop the oldest expectation and compare it with the DUT outputs.
   task automatic checkOutput(input string name);
      out_t act;
      out_t req;
      act = {bus.core_rst_n, bus.busy, bus.done, bus.pass, bus.fail, bus.match_cnt, bus.cycle_cnt};
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s: no expected entry queued", name);
      end else begin
         req = sb.pop_front();
         if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual rstn=%0b busy=%0b done=%0b pass=%0b fail=%0b match_cnt=%0d cycle_cnt=%0d required rstn=%0b busy=%0b done=%0b pass=%0b fail=%0b match_cnt=%0d cycle_cnt=%0d",
                     name, act.rstn, act.busy, act.done, act.pass, act.fail, act.mcnt, act.ccnt,
                     req.rstn, req.busy, req.done, req.pass, req.fail, req.mcnt, req.ccnt);
         end
      end
   endtask

   task automatic cyc(input logic start, input logic we, input logic addr, input logic [127:0] data,
                      input logic [127:0] st, input out_t e, input string name);
      applyStimulus(mk(start, we, addr, data, st, e));
      checkOutput(name);
   endtask

   task automatic expectNow(input out_t e, input string name);
      sb.push_back(e);
      checkOutput(name);
   endtask

   // Optionally load both table entries, start, and walk through the hold window.
   task automatic startRun(input logic we, input logic [127:0] d0, input logic [127:0] d1, input out_t frozen);
      if (we) cyc(1'b0, 1'b1, 1'b0, d0, '0, frozen, "write_exp0");
      cyc(1'b1, we, 1'b1, d1, '0, holdO(), "start");
      for (int i = 1; i < RH; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, holdO(), $sformatf("hold%0d", i));
      cyc(1'b0, 1'b0, 1'b0, '0, '0, runO(0, 0), "run_entry");
   endtask

   initial begin
      logic [127:0] st;
      out_t e;
      bus.start = 1'b0; bus.exp_we = 1'b0; bus.exp_addr = 1'b0;
      bus.exp_data = '0; bus.state_i = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      expectNow(idleO(), "reset_state");
      rst_n = 1'b1;

      // Table vectors: load {A,B}, start, 4 HOLD cycles (start and write in HOLD ignored), then order check.
      tv.push_back(mk(1'b0, 1'b1, 1'b0, A,  '0, idleO()));
      tv.push_back(mk(1'b1, 1'b1, 1'b1, B,  '0, holdO()));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, holdO()));
      tv.push_back(mk(1'b1, 1'b0, 1'b0, '0, '0, holdO()));
      tv.push_back(mk(1'b0, 1'b1, 1'b0, B,  '0, holdO()));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, runO(0, 0)));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, runO(0, 1)));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, '0, '0, runO(0, 2)));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, '0, B,  runO(0, 3)));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, '0, A,  runO(1, 4)));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, '0, A,  runO(1, 5)));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, '0, A,  runO(1, 6)));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, '0, A,  runO(1, 7)));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, '0, A,  runO(1, 8)));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, '0, B,  passO(9)));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, '0, A,  passO(9)));
      tv.push_back(mk(1'b0, 1'b0, 1'b0, '0, B,  passO(9)));
      for (int i = 0; i < tv.size(); i++) begin
         applyStimulus(tv[i]);
         checkOutput($sformatf("vec%0d", i));
      end

      // Held value counts once: table {A,A}, A held, then away and back.
      startRun(1'b1, A, A, passO(9));
      for (int k = 0; k <= 6; k++) begin
         st = (k == 5) ? '0 : A;
         e  = (k < 6) ? runO(1, k + 1) : passO(7);
         cyc(1'b0, 1'b0, 1'b0, '0, st, e, $sformatf("held_k%0d", k));
      end

      // Ciphertext at RUN cycle 100, plaintext next; start at cycle 10 is ignored.
      startRun(1'b1, C, P, passO(7));
      for (int k = 0; k <= 101; k++) begin
         st = (k == 100) ? C : (k == 101) ? P : '0;
         if (k < 100) e = runO(0, k + 1);
         else if (k == 100) e = runO(1, 101);
         else e = passO(102);
         cyc(k == 10, 1'b0, 1'b0, '0, st, e, $sformatf("cipher_k%0d", k));
      end

      // No matching value: FAIL after exactly TO RUN cycles, then frozen.
      startRun(1'b0, '0, '0, passO(102));
      for (int k = 0; k < TO; k++) begin
         st = {96'h0, 32'(k + 1)};
         e  = (k < TO - 1) ? runO(0, k + 1) : failO(0, TO);
         cyc(1'b0, 1'b0, 1'b0, '0, st, e, $sformatf("timeout_k%0d", k));
      end
      for (int k = 0; k < 2; k++) cyc(1'b0, 1'b0, 1'b0, '0, C, failO(0, TO), "fail_frozen");

      // Final match on the very cycle the timeout would trigger: PASS wins.
      startRun(1'b0, '0, '0, failO(0, TO));
      for (int k = 0; k < TO; k++) begin
         st = (k == 50) ? C : (k == TO - 1) ? P : '0;
         if (k < 50) e = runO(0, k + 1);
         else if (k < TO - 1) e = runO(1, k + 1);
         else e = passO(TO);
         cyc(1'b0, 1'b0, 1'b0, '0, st, e, $sformatf("race_k%0d", k));
      end

      // RUN-time write to entry 0 is ignored (C still matches), then async reset mid-run.
      startRun(1'b0, '0, '0, passO(TO));
      for (int k = 0; k <= 14; k++) begin
         st = (k == 10) ? C : '0;
         cyc(1'b0, k == 3, 1'b0, P, st, runO((k >= 10) ? 1 : 0, k + 1), $sformatf("runwr_k%0d", k));
      end
      #2 rst_n = 1'b0;
      #1;
      expectNow(idleO(), "async_reset");
      @(posedge clk);
      #1;
      expectNow(idleO(), "reset_held");
      rst_n = 1'b1;

      // Cleared table {0,0}: zero only matches when the state changes back to it.
      startRun(1'b0, '0, '0, idleO());
      for (int k = 0; k <= 6; k++) begin
         st = (k == 1) ? 128'd5 : (k == 5) ? 128'd9 : '0;
         e  = (k == 6) ? passO(7) : runO((k >= 2) ? 1 : 0, k + 1);
         cyc(1'b0, 1'b0, 1'b0, '0, st, e, $sformatf("zero_k%0d", k));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
